if_cic_decimator: RTL and testbench
===================================

IF_CIC_DECIMATOR -- requirements
Module: if_cic_decimator

Interface
REQ-001 SHALL have parameter DATA_W, default 12: width of the signed two's-complement IF sample from the mixer-output ADC.
REQ-002 SHALL have parameter OUT_W, default DATA_W+24: width of the signed output; this is full CIC growth for N=3 and R≤256.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port clr, input, 1: synchronous clear of integrators, combs, frame counter and output register.
REQ-006 SHALL have port dec_ratio, input, 8: decimation ratio R; the values 0 and 1 are treated as 2.
REQ-007 SHALL have port in_data, input, DATA_W: the IF sample.
REQ-008 SHALL have port in_valid, input, 1: in_data is valid.
REQ-009 SHALL have port in_ready, output, 1: the block accepts in_data this cycle.
REQ-010 SHALL have port out_data, output, OUT_W: the decimated sample.
REQ-011 SHALL have port out_valid, output, 1: out_data is valid.
REQ-012 SHALL have port out_ready, input, 1: the consumer takes out_data this cycle.

Function
REQ-013 SHALL implement a 3-stage CIC decimator with differential delay 1:
- three cascaded integrators at the input rate;
- decimation by R;
- three cascaded combs at the output rate.
REQ-014 SHALL perform all integrator and comb arithmetic at OUT_W bits, modulo 2^OUT_W, with in_data sign-extended; wrap-around is intentional and is never flagged.
REQ-015 SHALL define an input accept as in_valid && in_ready on a rising edge; integrators and the frame counter advance only on an accept.
REQ-016 SHALL run the frame counter 0..R_lat-1 and wrap it to 0 after the accept made at count R_lat-1 (the frame-closing accept).
REQ-017 SHALL latch R_lat from dec_ratio when the counter is 0 and no accept is pending, and on reset and clr; a dec_ratio change mid-frame takes effect at the next frame.
REQ-018 SHALL, on the frame-closing accept, compute the combs from the updated integrator value and load the result into the output register with out_valid=1 on that same edge, giving a latency of 1 cycle.
REQ-019 SHALL hold out_valid and out_data stable until out_valid && out_ready.
REQ-020 SHALL drive in_ready = !(count==R_lat-1 && out_valid && !out_ready); only the frame-closing accept is back-pressured.
REQ-021 SHALL, when out_ready pops the register on the same edge as a frame-closing accept, load the new sample with out_valid remaining 1 and drop no data.
REQ-022 SHALL give clr priority over an accept made in the same cycle; the accepted sample is discarded.
REQ-023 SHALL make the output sequence equal to the 10-tap FIR (1+z^-1+z^-2+z^-3)^3 sampled at every R-th input when R=4 and the filter starts from zero state.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear integrators, combs, counter, out_data=0 and out_valid=0, and set R_lat=2.
REQ-025 SHALL hold in_ready=1 while in reset and immediately after it.

Configuration
REQ-026 SHALL use the macro IF_CIC_GAIN_NORM_EN to compile gain normalisation in or out.
- Defined: out_data = (y + 2^(s-1)) >>> s, sign-extended to OUT_W, with s = 3*ceil(log2(R_lat)); gain is unity for power-of-two R.
- Undefined: out_data = raw comb output y.
- Handshake and latency are identical in both cases.

Verification
REQ-027 SHALL cover: R=4, in_data=+1 every cycle, out_ready=1 -> out_data 20, 60, 64, 64, ... (normalised build: 0, 1, 1, 1).
REQ-028 SHALL cover: R=4, in_data=-1 step -> out_data -20, -60, -64, -64 as OUT_W two's complement.
REQ-029 SHALL cover: R=4, out_ready=0 after the first output -> in_ready drops only at count 3; on releasing out_ready, 20 then 60 arrive with no loss or duplicate.
REQ-030 SHALL cover: dec_ratio changed 4->8 at input 2 -> the first frame still closes after 4 accepts and later frames close every 8 accepts.
REQ-031 SHALL cover: rst_n pulsed low mid-frame with out_valid=1 -> out_valid=0 immediately; the next step response restarts at 20.
REQ-032 SHALL cover: dec_ratio=1 -> behaves as R=2; step +1 gives 4, 8, 8.

Source files
------------

// File: rtl/if_cic_decimator.sv
// 3-stage CIC decimator (differential delay 1) for the IF path, ratio 2..255.
// Optional gain normalisation is compiled in with the IF_CIC_GAIN_NORM_EN macro.
module if_cic_decimator #(
  parameter int DATA_W = 12,
  parameter int OUT_W  = DATA_W + 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [7:0]        dec_ratio,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [OUT_W-1:0] int1_q, int1_d, int2_q, int2_d, int3_q, int3_d;
  logic [OUT_W-1:0] dly1_q, dly1_d, dly2_q, dly2_d, dly3_q, dly3_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       r_lat_q, r_lat_d;

  logic [OUT_W-1:0] x_ext;
  logic [OUT_W-1:0] int1_sum, int2_sum, int3_sum;
  logic [OUT_W-1:0] comb1, comb2, comb3;
  logic [OUT_W-1:0] out_next;
  logic [7:0]       r_in;
  logic             last_cnt, accept, close;

  always_comb begin
    x_ext    = {{(OUT_W - DATA_W){in_data[DATA_W-1]}}, in_data};
    r_in     = (dec_ratio < 8'd2) ? 8'd2 : dec_ratio;
    last_cnt = (cnt_q == r_lat_q - 8'd1);
    // Only the frame-closing accept needs the output register to be free.
    in_ready = !(last_cnt && out_valid_q && !out_ready);
    accept   = in_valid && in_ready;
    close    = accept && last_cnt;
    int1_sum = int1_q + x_ext;
    int2_sum = int2_q + int1_sum;
    int3_sum = int3_q + int2_sum;
    comb1    = int3_sum - dly1_q;
    comb2    = comb1 - dly2_q;
    comb3    = comb2 - dly3_q;
  end

`ifdef IF_CIC_GAIN_NORM_EN
  // Shift of 3*ceil(log2(R)) removes the R^3 CIC gain, rounding half up.
  function automatic logic [4:0] norm_shift(input logic [7:0] r);
    logic [3:0] lg;
    lg = 4'd0;
    for (int b = 1; b <= 8; b++) begin
      if ((9'd1 << (b - 1)) < {1'b0, r}) lg = 4'(b);
    end
    return 5'(lg) + 5'(lg) + 5'(lg);
  endfunction

  logic [4:0]             shift_amt;
  logic signed [OUT_W:0]  y_ext, rnd_c, y_rnd;

  always_comb begin
    shift_amt = norm_shift(r_lat_q);
    y_ext     = $signed({comb3[OUT_W-1], comb3});
    rnd_c     = $signed((OUT_W + 1)'(1) << (shift_amt - 5'd1));
    y_rnd     = y_ext + rnd_c;
    out_next  = OUT_W'(y_rnd >>> shift_amt);
  end
`else
  assign out_next = comb3;
`endif

  always_comb begin
    int1_d      = int1_q;
    int2_d      = int2_q;
    int3_d      = int3_q;
    dly1_d      = dly1_q;
    dly2_d      = dly2_q;
    dly3_d      = dly3_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    r_lat_d     = r_lat_q;
    if (clr) begin
      int1_d      = '0;
      int2_d      = '0;
      int3_d      = '0;
      dly1_d      = '0;
      dly2_d      = '0;
      dly3_d      = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
      cnt_d       = 8'd0;
      r_lat_d     = r_in;
    end else begin
      if (accept) begin
        int1_d = int1_sum;
        int2_d = int2_sum;
        int3_d = int3_sum;
        cnt_d  = close ? 8'd0 : cnt_q + 8'd1;
      end
      if (close) begin
        dly1_d      = int3_sum;
        dly2_d      = comb1;
        dly3_d      = comb2;
        out_data_d  = out_next;
        out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      // Ratio is sampled only between frames so a frame never changes length.
      if (cnt_q == 8'd0) r_lat_d = r_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int1_q      <= '0;
      int2_q      <= '0;
      int3_q      <= '0;
      dly1_q      <= '0;
      dly2_q      <= '0;
      dly3_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= 8'd0;
      r_lat_q     <= 8'd2;
    end else begin
      int1_q      <= int1_d;
      int2_q      <= int2_d;
      int3_q      <= int3_d;
      dly1_q      <= dly1_d;
      dly2_q      <= dly2_d;
      dly3_q      <= dly3_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      r_lat_q     <= r_lat_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_if_cic_decimator.sv
// Self-checking bench for if_cic_decimator: a reference CIC model feeds a scoreboard.
// Follows IF_CIC_GAIN_NORM_EN so either build can be checked.
module tb_if_cic_decimator;

  localparam int DATA_W = 12;
  localparam int OUT_W  = DATA_W + 24;
`ifdef IF_CIC_GAIN_NORM_EN
  localparam bit NORM = 1'b1;
`else
  localparam bit NORM = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n, clr, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]        dec_ratio;
  logic [DATA_W-1:0] in_data;
  logic [OUT_W-1:0]  out_data;

  always #5 clk = ~clk;

  if_cic_decimator #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .dec_ratio (dec_ratio),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] obs_q[$];
  longint m_i1, m_i2, m_i3, h1, h2, h3;
  int     m_cnt, m_r;
  bit     m_ov;
  logic   ov_seen, rdy_seen;

  function automatic int eff_ratio(input logic [7:0] d);
    return (d < 8'd2) ? 2 : int'(d);
  endfunction

  // Frame-end value y in OUT_W two's complement, optionally normalised for ratio r.
  function automatic logic [OUT_W-1:0] model_out(input longint y, input int r);
    longint m, ys;
    int lg, s;
    m  = (longint'(1) << OUT_W) - 1;
    ys = y & m;
    if (ys >= (longint'(1) << (OUT_W - 1))) ys = ys - (longint'(1) << OUT_W);
    lg = 0;
    while ((1 << lg) < r) lg++;
    s = NORM ? 3 * lg : 0;
    if (s > 0) ys = (ys + (longint'(1) << (s - 1))) >>> s;
    return OUT_W'(ys & m);
  endfunction

  task automatic model_reset();
    m_i1 = 0; m_i2 = 0; m_i3 = 0;
    h1 = 0; h2 = 0; h3 = 0;
    m_cnt = 0; m_r = 2; m_ov = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic apply_reset();
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock of stimulus; records DUT outputs and advances the reference model.
  task automatic cycle(input logic v, input int d, input logic ordy, input logic c);
    bit     exp_rdy, acc;
    int     old_cnt;
    longint y;
    @(negedge clk);
    ov_seen   = out_valid;
    in_valid  = v;
    in_data   = DATA_W'(d);
    out_ready = ordy;
    clr       = c;
    #1;
    rdy_seen = in_ready;
    if (out_valid && ordy) obs_q.push_back(out_data);
    exp_rdy = !(m_cnt == m_r - 1 && m_ov && !ordy);
    acc     = v && exp_rdy;
    old_cnt = m_cnt;
    if (c) begin
      if (m_ov && !ordy) void'(exp_q.pop_back());
      m_i1 = 0; m_i2 = 0; m_i3 = 0; h1 = 0; h2 = 0; h3 = 0;
      m_cnt = 0; m_r = eff_ratio(dec_ratio); m_ov = 1'b0;
    end else begin
      if (m_ov && ordy) m_ov = 1'b0;
      if (acc) begin
        m_i1 += longint'(d);
        m_i2 += m_i1;
        m_i3 += m_i2;
        if (m_cnt == m_r - 1) begin
          y = m_i3 - 3 * h1 + 3 * h2 - h3;
          exp_q.push_back(model_out(y, m_r));
          h3 = h2; h2 = h1; h1 = m_i3;
          m_ov  = 1'b1;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
      if (old_cnt == 0) m_r = eff_ratio(dec_ratio);
    end
  endtask

  task automatic drain();
    repeat (3) cycle(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    dec_ratio = 8'd4; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    #3;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data got %h want 0", out_data); end
    apply_reset();
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_step(input int amp);
    logic [OUT_W-1:0] lit[3];
    logic [OUT_W-1:0] e, g;
    if (amp > 0) begin
      lit[0] = OUT_W'(NORM ? 0 : 20); lit[1] = OUT_W'(NORM ? 1 : 60); lit[2] = OUT_W'(NORM ? 1 : 64);
    end else begin
      lit[0] = OUT_W'(NORM ? 0 : -20); lit[1] = OUT_W'(NORM ? -1 : -60); lit[2] = OUT_W'(NORM ? -1 : -64);
    end
    dec_ratio = 8'd4;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, amp, 1'b1, 1'b0);
      if (i == 3) begin n_cmp++; if (ov_seen !== 1'b0) begin n_err++; $display("FAIL step_early_valid got %b want 0", ov_seen); end end
      if (i == 4) begin n_cmp++; if (ov_seen !== 1'b1) begin n_err++; $display("FAIL step_latency got %b want 1", ov_seen); end end
    end
    drain();
    n_cmp++; if (obs_q.size() !== 4) begin n_err++; $display("FAIL step_count amp=%0d got %0d want 4", amp, obs_q.size()); end
    while (obs_q.size() < 3) obs_q.push_back('x);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs_q[k] !== lit[k]) begin n_err++; $display("FAIL step_value amp=%0d idx=%0d got %h want %h", amp, k, obs_q[k], lit[k]); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL step_sb amp=%0d got %h want %h", amp, g, e); end
    end
  endtask

  task automatic test_backpressure();
    logic [OUT_W-1:0] e, g;
    dec_ratio = 8'd4;
    apply_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1, 1'b1, 1'b0);
    for (int i = 4; i < 10; i++) begin
      cycle(1'b1, 1, 1'b0, 1'b0);
      n_cmp++;
      if (rdy_seen !== (i < 7)) begin n_err++; $display("FAIL bp_in_ready cyc=%0d got %b want %b", i, rdy_seen, (i < 7)); end
    end
    #1;
    n_cmp++; if (out_data !== OUT_W'(NORM ? 0 : 20) || out_valid !== 1'b1) begin
      n_err++; $display("FAIL bp_hold got %h/%b want %h/1", out_data, out_valid, OUT_W'(NORM ? 0 : 20)); end
    for (int i = 10; i < 16; i++) begin
      cycle(1'b1, 1, 1'b1, 1'b0);
      if (i == 10) begin n_cmp++; if (rdy_seen !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b want 1", rdy_seen); end end
    end
    drain();
    n_cmp++; if (obs_q.size() !== 3) begin n_err++; $display("FAIL bp_count got %0d want 3", obs_q.size()); end
    while (obs_q.size() < 2) obs_q.push_back('x);
    n_cmp++; if (obs_q[0] !== OUT_W'(NORM ? 0 : 20)) begin n_err++; $display("FAIL bp_first got %h", obs_q[0]); end
    n_cmp++; if (obs_q[1] !== OUT_W'(NORM ? 1 : 60)) begin n_err++; $display("FAIL bp_second got %h", obs_q[1]); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL bp_sb got %h want %h", g, e); end
    end
  endtask

  task automatic test_ratio_change();
    logic [OUT_W-1:0] e, g;
    dec_ratio = 8'd4;
    apply_reset();
    for (int i = 0; i < 28; i++) begin
      if (i == 2) dec_ratio = 8'd8;
      cycle(1'b1, 3, 1'b1, 1'b0);
      if (i == 4 || i == 12 || i == 20) begin
        n_cmp++; if (ov_seen !== 1'b1) begin n_err++; $display("FAIL ratio_close cyc=%0d got %b want 1", i, ov_seen); end
      end
      if (i == 5 || i == 11 || i == 19) begin
        n_cmp++; if (ov_seen !== 1'b0) begin n_err++; $display("FAIL ratio_open cyc=%0d got %b want 0", i, ov_seen); end
      end
    end
    drain();
    n_cmp++; if (obs_q.size() !== 4) begin n_err++; $display("FAIL ratio_count got %0d want 4", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL ratio_sb got %h want %h", g, e); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [OUT_W-1:0] e, g;
    dec_ratio = 8'd4;
    apply_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1, 1'b1, 1'b0);
    cycle(1'b1, 1, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid got %b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL mid_async_data got %h want 0", out_data); end
    apply_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1, 1'b1, 1'b0);
    drain();
    if (obs_q.size() == 0) obs_q.push_back('x);
    n_cmp++; if (obs_q[0] !== OUT_W'(NORM ? 0 : 20)) begin n_err++; $display("FAIL mid_restart got %h", obs_q[0]); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL mid_sb got %h want %h", g, e); end
    end
  endtask

  task automatic test_ratio_one();
    logic [OUT_W-1:0] e, g;
    logic [OUT_W-1:0] lit[3];
    lit[0] = OUT_W'(NORM ? 1 : 4); lit[1] = OUT_W'(NORM ? 1 : 8); lit[2] = OUT_W'(NORM ? 1 : 8);
    dec_ratio = 8'd1;
    apply_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1, 1'b1, 1'b0);
    drain();
    n_cmp++; if (obs_q.size() !== 3) begin n_err++; $display("FAIL r1_count got %0d want 3", obs_q.size()); end
    while (obs_q.size() < 3) obs_q.push_back('x);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (obs_q[k] !== lit[k]) begin n_err++; $display("FAIL r1_value idx=%0d got %h want %h", k, obs_q[k], lit[k]); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL r1_sb got %h want %h", g, e); end
    end
  endtask

  task automatic test_clr();
    logic [OUT_W-1:0] e, g;
    dec_ratio = 8'd4;
    apply_reset();
    cycle(1'b1, 1, 1'b1, 1'b0);
    cycle(1'b1, 1, 1'b1, 1'b0);
    cycle(1'b1, 5, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1, 1'b1, 1'b0);
    drain();
    if (obs_q.size() == 0) obs_q.push_back('x);
    n_cmp++; if (obs_q[0] !== OUT_W'(NORM ? 0 : 20)) begin n_err++; $display("FAIL clr_restart got %h", obs_q[0]); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL clr_sb got %h want %h", g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_step(1);
    test_step(-1);
    test_backpressure();
    test_ratio_change();
    test_reset_midframe();
    test_ratio_one();
    test_clr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
